// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for the RV32 decode/issue stage.
// Counts in-flight writers per architectural register and stalls issue on RAW hazards.
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic        issue_rd_wren_i,
  input  logic [4:0]  issue_rd_addr_i,
  input  logic        rs1_used_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        stall_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        kill_valid_i,
  input  logic [4:0]  kill_rd_addr_i,
  output logic [31:0] busy_o,
  output logic        err_o
);

  localparam int unsigned SUM_W = CNT_W + 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SUM_W-1:0] sum_t;

  localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

  cnt_t [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] wb_hit;
  logic [31:0] kill_hit;
  logic [31:0] issue_hit;
  logic        raw1;
  logic        raw2;
  logic        sat;
  logic        fire;

  // One-hot decode of the retire events; x0 never participates.
  // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    wb_hit   = '0;
    kill_hit = '0;
    if (wb_valid_i && (wb_rd_addr_i != 5'd0)) begin
      wb_hit[wb_rd_addr_i] = 1'b1;
    end
    if (kill_valid_i && (kill_rd_addr_i != 5'd0)) begin
      kill_hit[kill_rd_addr_i] = 1'b1;
    end
  end

  // A same-cycle write-back is visible to this cycle's readers, so it cancels one pending count.
  always_comb begin
    raw1 = rs1_used_i && (rs1_addr_i != 5'd0) &&
           (cnt_q[rs1_addr_i] != cnt_t'(wb_hit[rs1_addr_i]));
    raw2 = rs2_used_i && (rs2_addr_i != 5'd0) &&
           (cnt_q[rs2_addr_i] != cnt_t'(wb_hit[rs2_addr_i]));
    sat  = issue_rd_wren_i && (issue_rd_addr_i != 5'd0) &&
           (cnt_q[issue_rd_addr_i] == CNT_MAX) &&
           !wb_hit[issue_rd_addr_i] && !kill_hit[issue_rd_addr_i];
  end

  assign stall_o = issue_valid_i && (raw1 || raw2 || sat);
  assign fire    = issue_valid_i && !stall_o && issue_rd_wren_i && (issue_rd_addr_i != 5'd0);

  always_comb begin
    issue_hit = '0;
    if (fire) begin
      issue_hit[issue_rd_addr_i] = 1'b1;
    end
  end

  // Net delta per counter in one update; a result below zero clamps and flags an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int n = 1; n < 32; n++) begin
      sum_t up;
      sum_t dec;
      up  = {1'b0, cnt_q[n]} + sum_t'(issue_hit[n]);
      dec = sum_t'(wb_hit[n]) + sum_t'(kill_hit[n]);
      if (up < dec) begin
        cnt_d[n] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[n] = cnt_t'(up - dec);
      end
    end
  end

  // NOTE: the counter array is plain flops, not RAM, so it is cleared by the async reset
  // and in-flight state vanishes the moment rst_ni falls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: sequential state is assigned with non-blocking <= so all flops sample together.
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int n = 1; n < 32; n++) begin
      busy_o[n] = (cnt_q[n] != '0);
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: the driver queues hand-computed expectations,
// a monitor on the falling edge pops and compares them against stall_o/busy_o/err_o.
module tb_reg_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic        issue_rd_wren_i;
  logic [4:0]  issue_rd_addr_i;
  logic        rs1_used_i;
  logic [4:0]  rs1_addr_i;
  logic        rs2_used_i;
  logic [4:0]  rs2_addr_i;
  logic        stall_o;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_addr_i;
  logic        kill_valid_i;
  logic [4:0]  kill_rd_addr_i;
  logic [31:0] busy_o;
  logic        err_o;

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_wren_i (issue_rd_wren_i),
    .issue_rd_addr_i (issue_rd_addr_i),
    .rs1_used_i      (rs1_used_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_used_i      (rs2_used_i),
    .rs2_addr_i      (rs2_addr_i),
    .stall_o         (stall_o),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .kill_valid_i    (kill_valid_i),
    .kill_rd_addr_i  (kill_rd_addr_i),
    .busy_o          (busy_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] busy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".stall"}, 32'(stall_o), 32'(e.stall));
        check({e.name, ".busy"},  busy_o,        e.busy);
        check({e.name, ".err"},   32'(err_o),    32'(e.err));
      end
    end
  end

  task automatic drive(input bit iv, input bit wr, input int rd,
                       input bit u1, input int a1, input bit u2, input int a2,
                       input bit wv, input int wa, input bit kv, input int ka);
    issue_valid_i   = iv;
    issue_rd_wren_i = wr;
    issue_rd_addr_i = 5'(rd);
    rs1_used_i      = u1;
    rs1_addr_i      = 5'(a1);
    rs2_used_i      = u2;
    rs2_addr_i      = 5'(a2);
    wb_valid_i      = wv;
    wb_rd_addr_i    = 5'(wa);
    kill_valid_i    = kv;
    kill_rd_addr_i  = 5'(ka);
  endtask

  // One cycle: drive just after the rising edge and queue what the monitor must see.
  task automatic cyc(input string nm, input bit iv, input bit wr, input int rd,
                     input bit u1, input int a1, input bit u2, input int a2,
                     input bit wv, input int wa, input bit kv, input int ka,
                     input bit es, input logic [31:0] eb, input bit ee);
    exp_t e;
    @(posedge clk_i);
    #1;
    drive(iv, wr, rd, u1, a1, u2, a2, wv, wa, kv, ka);
    e.name  = nm;
    e.stall = es;
    e.busy  = eb;
    e.err   = ee;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [31:0] eb, input bit ee);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, eb, ee);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("in_reset_a", 32'h0, 1'b0);
    idle("in_reset_b", 32'h0, 1'b0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;

    idle("idle", 32'h0, 1'b0);
    cyc("x0_issue",     1, 1, 0,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h0, 1'b0);
    idle("x0_after", 32'h0, 1'b0);

    // RAW on rs1 with same-cycle write-back bypass
    cyc("issue5",       1, 1, 5,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h0,  1'b0);
    cyc("raw_rs1_5",    1, 0, 0,  1, 5, 0, 0,  0, 0,  0, 0,  1'b1, 32'h20, 1'b0);
    cyc("no_valid",     0, 0, 0,  1, 5, 0, 0,  0, 0,  0, 0,  1'b0, 32'h20, 1'b0);
    cyc("raw_bypass",   1, 0, 0,  1, 5, 0, 0,  1, 5,  0, 0,  1'b0, 32'h20, 1'b0);
    idle("wb5_done", 32'h0, 1'b0);

    // Saturation at 3 writers to x7
    cyc("iss7_a",       1, 1, 7,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h0,  1'b0);
    cyc("iss7_b",       1, 1, 7,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h80, 1'b0);
    cyc("iss7_c",       1, 1, 7,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h80, 1'b0);
    cyc("sat7",         1, 1, 7,  0, 0, 0, 0,  0, 0,  0, 0,  1'b1, 32'h80, 1'b0);
    cyc("sat7_wb",      1, 1, 7,  0, 0, 0, 0,  1, 7,  0, 0,  1'b0, 32'h80, 1'b0);
    cyc("sat7_again",   1, 1, 7,  0, 0, 0, 0,  0, 0,  0, 0,  1'b1, 32'h80, 1'b0);
    cyc("wb7_1",        0, 0, 0,  0, 0, 0, 0,  1, 7,  0, 0,  1'b0, 32'h80, 1'b0);
    cyc("wb7_2_raw",    1, 0, 0,  0, 0, 1, 7,  1, 7,  0, 0,  1'b1, 32'h80, 1'b0);
    cyc("wb7_3_bypass", 1, 0, 0,  0, 0, 1, 7,  1, 7,  0, 0,  1'b0, 32'h80, 1'b0);
    idle("drain7", 32'h0, 1'b0);

    // wb + kill on the same register in one cycle
    cyc("iss9_a",       1, 1, 9,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h0,   1'b0);
    cyc("iss9_b",       1, 1, 9,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h200, 1'b0);
    cyc("wb_kill9",     0, 0, 0,  0, 0, 0, 0,  1, 9,  1, 9,  1'b0, 32'h200, 1'b0);
    idle("after9", 32'h0, 1'b0);

    // issue + wb + kill on x3: 2 -> 1, then a single wb drains it without underflow
    cyc("iss3_a",       1, 1, 3,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h0, 1'b0);
    cyc("iss3_b",       1, 1, 3,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h8, 1'b0);
    cyc("iwk3",         1, 1, 3,  0, 0, 0, 0,  1, 3,  1, 3,  1'b0, 32'h8, 1'b0);
    cyc("wb3",          0, 0, 0,  0, 0, 0, 0,  1, 3,  0, 0,  1'b0, 32'h8, 1'b0);
    idle("drain3", 32'h0, 1'b0);

    // Underflow sets sticky err
    cyc("kill12",       0, 0, 0,  0, 0, 0, 0,  0, 0,  1, 12, 1'b0, 32'h0, 1'b0);
    idle("err_set", 32'h0, 1'b1);
    cyc("iss5_again",   1, 1, 5,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h0,  1'b1);
    cyc("iss9_again",   1, 1, 9,  0, 0, 0, 0,  0, 0,  0, 0,  1'b0, 32'h20, 1'b1);
    idle("busy_220", 32'h220, 1'b1);

    // Asynchronous reset mid-cycle clears everything before the next edge
    @(posedge clk_i);
    #1;
    drive(1, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
    #1 rst_ni = 1'b0;
    e.name  = "async_rst";
    e.stall = 1'b0;
    e.busy  = 32'h0;
    e.err   = 1'b0;
    exp_q.push_back(e);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    cyc("post_rst_raw", 1, 0, 0,  1, 5, 1, 9,  0, 0,  0, 0,  1'b0, 32'h0, 1'b0);
    idle("post_rst", 32'h0, 1'b0);

    @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard for the pipelined RV32 core. It sits on the read side of the integer register file, in the decode/issue stage. It tracks how many in-flight instructions will still write each architectural register, and stalls issue on read-after-write hazards. Pending counts are retired when the write-back stage drives the register file write port, or when a squashed instruction is killed after a branch mispredict.

## Interface
Parameters:
- CNT_W, default 2: width of each per-register pending counter. The maximum number of in-flight writes per register is 2^CNT_W − 1.

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- issue_valid_i  input  1  decode has an instruction ready to issue
- issue_rd_wren_i  input  1  issuing instruction writes a destination register
- issue_rd_addr_i  input  5  destination register of issuing instruction
- rs1_used_i  input  1  issuing instruction reads rs1
- rs1_addr_i  input  5  source register 1 address
- rs2_used_i  input  1  issuing instruction reads rs2
- rs2_addr_i  input  5  source register 2 address
- stall_o  output  1  issue blocked this cycle (combinational)
- wb_valid_i  input  1  write-back is writing the register file this cycle (mirrors rd_wren)
- wb_rd_addr_i  input  5  register being written back
- kill_valid_i  input  1  a squashed instruction with a destination is leaving the pipe without writing
- kill_rd_addr_i  input  5  destination of the killed instruction
- busy_o  output  32  bit n = 1 when counter n ≠ 0 (registered state)
- err_o  output  1  sticky underflow error

## Operation
- State: 31 counters cnt[1..31] of CNT_W bits, plus the err flag. x0 is never tracked and busy_o[0] is always 0.
- Effective count used for hazard checks:
  - eff[n] = cnt[n] − (wb_valid_i && wb_rd_addr_i==n).
  - The register file writes on the falling edge, so a value written back this cycle is readable by this cycle's issue.
- RAW hazard: rsX_used_i && rsX_addr_i≠0 && eff[rsX_addr_i]≠0, for X=1,2.
- Saturation hazard: issue_rd_wren_i && issue_rd_addr_i≠0 && cnt[issue_rd_addr_i]==2^CNT_W−1 with no same-cycle wb/kill to that register.
- stall_o = issue_valid_i && (RAW1 || RAW2 || saturation). When issue_valid_i=0, stall_o=0.
- Issue fires when issue_valid_i && !stall_o && issue_rd_wren_i && issue_rd_addr_i≠0. It adds +1 to cnt[issue_rd_addr_i].
- wb_valid_i with a nonzero address adds −1. kill_valid_i with a nonzero address adds −1.
- All three events may coincide on the same register; the net delta is applied in one update:
  - issue + wb → unchanged
  - wb + kill → −2
  - issue + wb + kill → −1
- Underflow: if the net delta would take a counter below 0, the counter clamps to 0 and err is set. err stays set until reset.
- WAW: consecutive writers to the same register simply raise the count. The register stays busy until all of them retire.

## Timing
- Reset (asynchronous assert, synchronous release to clk_i): all counters 0, busy_o=0, err_o=0, stall_o=0.
- If reset asserts mid-operation, all pending state is discarded immediately. The pipeline is reset in parallel.
- stall_o has zero latency: it is combinational from the inputs and the current counters.
- busy_o and err_o update one cycle after the causing edge, i.e. they are registered.
- An issue at edge k makes a dependent instruction stall from cycle k+1 onward. A write-back in cycle m lets that dependent instruction issue in cycle m (same-cycle bypass).
- Wrap-around is impossible by construction: saturation stalls issue, and underflow clamps.

## Test plan
- Reset then idle: busy_o=0, err_o=0, stall_o=0. Issue x0 as destination → busy_o stays 0.
- Issue rd=5, then next cycle an instruction with rs1=5 → stall_o=1. Raise wb_valid_i with wb_rd_addr_i=5 → stall_o=0 that same cycle, and busy_o[5]=0 the next cycle.
- CNT_W=2: issue rd=7 three times, then a fourth writer to rd=7 → stall_o=1, cnt stays 3. A wb to 7 in the same cycle → that issue fires and cnt stays 3.
- Issue rd=9 twice, then wb and kill to 9 in the same cycle → busy_o[9]=0 and err_o=0.
- kill_valid_i to rd=12 while cnt[12]=0 → counter stays 0, err_o=1. err_o holds until rst_ni goes low, then returns to 0.
- Assert rst_ni=0 asynchronously while busy_o=32'h0000_0220 → busy_o=0 before the next clock edge.
